cdf_lut_gen: RTL and testbench

// - Integer histogram-equalisation LUT generator; successor to the floating-point cumulative-sum stage.
// - Takes a streamed histogram, one bin per beat, bin 0 first.
// - Builds the CDF in an external dual-port RAM.
// - Then emits lut[i] = round((cdf[i]-cdf_min)*(L-1)/(total-cdf_min)) as a stream.
// - Uses an internal radix-2 divider, so no float IP is needed.
// - Sits between the histogram counter and the pixel remap stage of his_eq.

---
 rtl/cdf_lut_gen.sv | 181 ++++++++++++++++++
 tb/tb_cdf_lut_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdf_lut_gen.sv
// Histogram-equalisation LUT generator: accumulates a streamed histogram into an
// external CDF RAM, then emits one rounded, scaled LUT entry per bin using a radix-2 divider.
module cdf_lut_gen #(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_VDATA_WIDTH = 8,
  parameter int C_OUT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     hist_valid,
  input  logic [C_DATA_WIDTH-1:0]  hist_data,
  output logic                     ram_wea,
  output logic [C_VDATA_WIDTH-1:0] ram_addra,
  output logic [C_DATA_WIDTH-1:0]  ram_dina,
  output logic                     ram_rdb,
  output logic [C_VDATA_WIDTH-1:0] ram_addrb,
  input  logic [C_DATA_WIDTH-1:0]  ram_doutb,
  output logic                     lut_valid,
  output logic [C_VDATA_WIDTH-1:0] lut_addr,
  output logic [C_OUT_WIDTH-1:0]   lut_data,
  output logic                     busy,
  output logic                     cal_eq_part_done,
  output logic                     cal_eq_done,
  output logic                     degenerate,
  output logic                     overflow
);

  localparam int NW = C_DATA_WIDTH + C_OUT_WIDTH + 1;
  localparam int CW = $clog2(C_OUT_WIDTH + 1);
  localparam int unsigned LEVELS_M1 = (1 << C_OUT_WIDTH) - 1;
  localparam logic [C_VDATA_WIDTH-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CALC, S_DIV, S_EMIT} state_t;

  state_t                    state_q, state_d;
  logic [C_DATA_WIDTH-1:0]   acc, cdf_min, d_q;
  logic [C_VDATA_WIDTH-1:0]  bin_cnt;
  logic                      calc_ph;
  logic [NW-1:0]             rem_q, dsh_q, num;
  logic [C_OUT_WIDTH-1:0]    quo_q;
  logic [CW-1:0]             div_cnt;
  logic                      part_done_q, degenerate_q, overflow_q;

  logic [C_DATA_WIDTH:0]     sum;
  logic [C_DATA_WIDTH-1:0]   new_acc, min_next;
  logic                      last_bin, q_bit;

  // Saturating running sum; the first nonzero CDF value becomes cdf_min.
  assign sum      = {1'b0, acc} + {1'b0, hist_data};
  assign new_acc  = sum[C_DATA_WIDTH] ? '1 : sum[C_DATA_WIDTH-1:0];
  assign min_next = (cdf_min == '0) ? new_acc : cdf_min;
  assign last_bin = (bin_cnt == LAST_BIN);
  assign q_bit    = (d_q != '0) && (rem_q >= dsh_q);

  // Adding D/2 before the floor divide rounds to nearest.
  always_comb begin
    num = '0;
    if (!(ram_doutb < cdf_min) && (d_q != '0))
      num = NW'(ram_doutb - cdf_min) * NW'(LEVELS_M1) + NW'(d_q >> 1);
  end

  assign busy             = (state_q != S_IDLE);
  assign cal_eq_part_done = part_done_q;
  assign degenerate       = degenerate_q;
  assign overflow         = overflow_q;

  // hist_valid is a pure valid (no ready): a beat is taken on every cycle it is high
  // in ACCUM and dropped in every other state; lut_valid is a 1-cycle strobe with no backpressure.
  always_comb begin
    state_d     = state_q;
    ram_wea     = 1'b0;
    ram_addra   = '0;
    ram_dina    = '0;
    ram_rdb     = 1'b0;
    ram_addrb   = '0;
    lut_valid   = 1'b0;
    lut_addr    = '0;
    lut_data    = '0;
    cal_eq_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_ACCUM;
      S_ACCUM: begin
        if (hist_valid) begin
          ram_wea   = 1'b1;
          ram_addra = bin_cnt;
          ram_dina  = new_acc;
          if (last_bin) state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!calc_ph) begin
          ram_rdb   = 1'b1;
          ram_addrb = bin_cnt;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: if (div_cnt == '0) state_d = S_EMIT;
      S_EMIT: begin
        lut_valid = 1'b1;
        lut_addr  = bin_cnt;
        lut_data  = quo_q;
        if (last_bin) begin
          cal_eq_done = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      acc          <= '0;
      cdf_min      <= '0;
      d_q          <= '0;
      bin_cnt      <= '0;
      calc_ph      <= 1'b0;
      rem_q        <= '0;
      dsh_q        <= '0;
      quo_q        <= '0;
      div_cnt      <= '0;
      part_done_q  <= 1'b0;
      degenerate_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      part_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc          <= '0;
            cdf_min      <= '0;
            d_q          <= '0;
            bin_cnt      <= '0;
            calc_ph      <= 1'b0;
            degenerate_q <= 1'b0;
            overflow_q   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (hist_valid) begin
            acc     <= new_acc;
            cdf_min <= min_next;
            bin_cnt <= bin_cnt + 1'b1;
            if (sum[C_DATA_WIDTH]) overflow_q <= 1'b1;
            if (last_bin) begin
              d_q          <= new_acc - min_next;
              degenerate_q <= (new_acc == min_next);
              part_done_q  <= 1'b1;
              calc_ph      <= 1'b0;
            end
          end
        end
        S_CALC: begin
          calc_ph <= ~calc_ph;
          if (calc_ph) begin
            rem_q   <= num;
            dsh_q   <= NW'(d_q) << (C_OUT_WIDTH - 1);
            quo_q   <= '0;
            div_cnt <= CW'(C_OUT_WIDTH - 1);
          end
        end
        // Restoring divide: one quotient bit per cycle, MSB first.
        S_DIV: begin
          if (q_bit) rem_q <= rem_q - dsh_q;
          quo_q   <= {quo_q[C_OUT_WIDTH-2:0], q_bit};
          dsh_q   <= dsh_q >> 1;
          div_cnt <= div_cnt - 1'b1;
        end
        S_EMIT: bin_cnt <= bin_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_lut_gen.sv
// Bench for cdf_lut_gen: a small N=4 instance driven from a vector table and a
// default-size instance driven with random histograms against an arithmetic reference model.
module tb_cdf_lut_gen;

  localparam int DW = 32, VW = 8, OW = 8, N = 256, PERIOD = OW + 3;
  localparam int SDW = 4, SVW = 2, SN = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- default-size DUT ----------------
  logic          b_start = 1'b0, b_hist_valid = 1'b0;
  logic [DW-1:0] b_hist_data = '0;
  logic          b_ram_wea, b_ram_rdb, b_lut_valid, b_busy, b_cal_eq_part_done, b_cal_eq_done;
  logic          b_degenerate, b_overflow;
  logic [VW-1:0] b_ram_addra, b_ram_addrb, b_lut_addr;
  logic [DW-1:0] b_ram_dina, b_ram_doutb;
  logic [OW-1:0] b_lut_data;

  cdf_lut_gen #(.C_DATA_WIDTH(DW), .C_VDATA_WIDTH(VW), .C_OUT_WIDTH(OW)) u_big (
    .clk(clk), .reset_n(reset_n), .start(b_start), .hist_valid(b_hist_valid),
    .hist_data(b_hist_data), .ram_wea(b_ram_wea), .ram_addra(b_ram_addra),
    .ram_dina(b_ram_dina), .ram_rdb(b_ram_rdb), .ram_addrb(b_ram_addrb),
    .ram_doutb(b_ram_doutb), .lut_valid(b_lut_valid), .lut_addr(b_lut_addr),
    .lut_data(b_lut_data), .busy(b_busy), .cal_eq_part_done(b_cal_eq_part_done),
    .cal_eq_done(b_cal_eq_done), .degenerate(b_degenerate), .overflow(b_overflow)
  );

  logic [DW-1:0] b_mem [N];
  logic          b_mem_clr = 1'b0;
  always @(posedge clk) begin
    if (b_mem_clr) for (int i = 0; i < N; i++) b_mem[i] <= '0;
    else if (b_ram_wea) b_mem[b_ram_addra] <= b_ram_dina;
    if (b_ram_rdb) b_ram_doutb <= b_mem[b_ram_addrb];
  end

  // ---------------- small DUT (N=4, 4-bit counts) ----------------
  logic           s_start = 1'b0, s_hist_valid = 1'b0;
  logic [SDW-1:0] s_hist_data = '0;
  logic           s_ram_wea, s_ram_rdb, s_lut_valid, s_busy, s_cal_eq_part_done, s_cal_eq_done;
  logic           s_degenerate, s_overflow;
  logic [SVW-1:0] s_ram_addra, s_ram_addrb, s_lut_addr;
  logic [SDW-1:0] s_ram_dina, s_ram_doutb;
  logic [7:0]     s_lut_data;

  cdf_lut_gen #(.C_DATA_WIDTH(SDW), .C_VDATA_WIDTH(SVW), .C_OUT_WIDTH(8)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .hist_valid(s_hist_valid),
    .hist_data(s_hist_data), .ram_wea(s_ram_wea), .ram_addra(s_ram_addra),
    .ram_dina(s_ram_dina), .ram_rdb(s_ram_rdb), .ram_addrb(s_ram_addrb),
    .ram_doutb(s_ram_doutb), .lut_valid(s_lut_valid), .lut_addr(s_lut_addr),
    .lut_data(s_lut_data), .busy(s_busy), .cal_eq_part_done(s_cal_eq_part_done),
    .cal_eq_done(s_cal_eq_done), .degenerate(s_degenerate), .overflow(s_overflow)
  );

  logic [SDW-1:0] s_mem [SN];
  logic           s_mem_clr = 1'b0;
  always @(posedge clk) begin
    if (s_mem_clr) for (int i = 0; i < SN; i++) s_mem[i] <= '0;
    else if (s_ram_wea) s_mem[s_ram_addra] <= s_ram_dina;
    if (s_ram_rdb) s_ram_doutb <= s_mem[s_ram_addrb];
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, failures = 0;
  longint cyc = 0;
  logic [OW-1:0] exp_q[$];
  int lut_seen, wea_cnt, conflict_cnt, done_cnt, part_cnt;
  logic [VW-1:0] done_addr;
  longint last_rdb, last_valid, last_wea, part_cyc;
  bit rdb3_seen;
  logic [7:0] s_lut [SN];
  int s_cnt, s_done_cnt;
  logic [SVW-1:0] s_done_addr;

  logic [DW-1:0] b_hist [N];
  longint unsigned m_cdf [N];
  longint unsigned m_lut [N];
  bit m_deg, m_ovf;

  typedef struct packed {
    logic [SN-1:0][SDW-1:0] hist;  // element [i] is bin i
    logic [SN-1:0][SDW-1:0] cdf;
    logic [SN-1:0][7:0]     lut;
    logic                   deg;
    logic                   ovf;
  } svec_t;
  svec_t svecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic b_any_out();
    return |{b_ram_wea, b_ram_addra, b_ram_dina, b_ram_rdb, b_ram_addrb, b_lut_valid,
             b_lut_addr, b_lut_data, b_busy, b_cal_eq_part_done, b_cal_eq_done,
             b_degenerate, b_overflow};
  endfunction

  function automatic logic s_any_out();
    return |{s_ram_wea, s_ram_addra, s_ram_dina, s_ram_rdb, s_ram_addrb, s_lut_valid,
             s_lut_addr, s_lut_data, s_busy, s_cal_eq_part_done, s_cal_eq_done,
             s_degenerate, s_overflow};
  endfunction

  // Reference: saturating prefix sum, first nonzero CDF as minimum, rounded scale.
  function automatic void build_model();
    longint unsigned acc, mn, d;
    bit found;
    acc = 0; mn = 0; found = 0; m_ovf = 0;
    for (int i = 0; i < N; i++) begin
      acc += b_hist[i];
      if (acc > 64'hFFFF_FFFF) begin acc = 64'hFFFF_FFFF; m_ovf = 1; end
      m_cdf[i] = acc;
      if (!found && acc != 0) begin found = 1; mn = acc; end
    end
    d = acc - mn;
    m_deg = (d == 0);
    for (int i = 0; i < N; i++)
      m_lut[i] = (d == 0 || m_cdf[i] < mn) ? 0 : ((m_cdf[i] - mn) * 255 + d / 2) / d;
  endfunction

  // Samples both DUTs just before the coming edge, then advances one cycle.
  task automatic tick();
    #1;
    if (b_ram_wea) begin wea_cnt++; last_wea = cyc; end
    if (b_ram_wea && b_ram_rdb) conflict_cnt++;
    if (b_ram_rdb) begin
      last_rdb = cyc;
      if (b_ram_addrb == VW'(3)) rdb3_seen = 1'b1;
    end
    if (b_lut_valid) begin
      check("lut_addr", b_lut_addr, lut_seen);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL lut_unexpected: actual entry at addr %0d, required none", b_lut_addr);
      end else begin
        check($sformatf("lut_data[%0d]", lut_seen), b_lut_data, exp_q.pop_front());
      end
      check("rdb_to_lut_latency", cyc - last_rdb, OW + 2);
      if (lut_seen > 0) check("lut_period", cyc - last_valid, PERIOD);
      last_valid = cyc;
      lut_seen++;
    end
    if (b_cal_eq_done) begin done_cnt++; done_addr = b_lut_addr; end
    if (b_cal_eq_part_done) begin part_cnt++; part_cyc = cyc; end
    if (s_lut_valid) begin s_lut[s_lut_addr] = s_lut_data; s_cnt++; end
    if (s_cal_eq_done) begin s_done_cnt++; s_done_addr = s_lut_addr; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- drivers ----------------
  task automatic b_feed(input bit gaps, input bit strays);
    lut_seen = 0; wea_cnt = 0; conflict_cnt = 0; done_cnt = 0; part_cnt = 0;
    done_addr = '0; rdb3_seen = 1'b0; last_rdb = 0; last_valid = 0; last_wea = 0; part_cyc = 0;
    b_mem_clr = 1'b1; tick(); b_mem_clr = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("busy_after_start", b_busy, 1);
    check("flags_cleared_by_start", {b_degenerate, b_overflow}, 0);
    for (int i = 0; i < N; i++) begin
      b_hist_valid = 1'b1;
      b_hist_data  = b_hist[i];
      tick();
      b_hist_valid = 1'b0;
      b_hist_data  = $urandom;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          if (strays) b_start = 1'($urandom_range(0, 1));
          tick();
          b_start = 1'b0;
        end
      end
    end
  endtask

  task automatic b_frame(input string tag, input bit gaps, input bit strays);
    int t, mm;
    build_model();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(OW'(m_lut[i]));
    b_feed(gaps, strays);
    t = 0;
    while (done_cnt == 0 && t < N * PERIOD + 100) begin
      if (strays) begin
        b_hist_valid = 1'($urandom_range(0, 1));
        b_start      = 1'($urandom_range(0, 1));
        b_hist_data  = $urandom;
      end
      tick();
      t++;
    end
    b_hist_valid = 1'b0;
    b_start      = 1'b0;
    tick();
    check({tag, "_idle_after_done"}, b_busy, 0);
    if (strays) begin
      b_hist_valid = 1'b1;
      repeat (3) tick();
      b_hist_valid = 1'b0;
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_addr"}, done_addr, N - 1);
    check({tag, "_lut_count"}, lut_seen, N);
    check({tag, "_part_done_count"}, part_cnt, 1);
    check({tag, "_part_done_after_last_beat"}, part_cyc - last_wea, 1);
    check({tag, "_ram_write_count"}, wea_cnt, N);
    check({tag, "_wea_rdb_overlap"}, conflict_cnt, 0);
    check({tag, "_degenerate"}, b_degenerate, m_deg);
    check({tag, "_overflow"}, b_overflow, m_ovf);
    mm = 0;
    for (int i = 0; i < N; i++) begin
      if (b_mem[i] !== DW'(m_cdf[i])) begin
        if (mm == 0) $display("  first cdf difference at bin %0d: ram=%0d model=%0d", i, b_mem[i], m_cdf[i]);
        mm++;
      end
    end
    check({tag, "_ram_cdf_mismatches"}, mm, 0);
  endtask

  task automatic reset_mid_frame();
    int t;
    build_model();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(OW'(m_lut[i]));
    b_feed(1'b0, 1'b0);
    t = 0;
    while (!rdb3_seen && t < 2000) begin tick(); t++; end
    check("reset_reached_bin3", rdb3_seen, 1);
    tick();
    tick();  // now inside the divide of bin 3
    check("reset_busy_before", b_busy, 1);
    check("reset_degenerate_before", b_degenerate, 1);
    reset_n = 1'b0;
    #1;
    check("reset_outputs_zero_immediate", b_any_out(), 0);
    tick();
    check("reset_outputs_zero_next_cycle", b_any_out(), 0);
    reset_n = 1'b1;
    tick();
    check("reset_idle_after_release", b_busy, 0);
    check("reset_lut_entries_before_abort", lut_seen, 3);
  endtask

  task automatic s_run(input int v);
    int t;
    s_cnt = 0; s_done_cnt = 0; s_done_addr = '0;
    for (int i = 0; i < SN; i++) s_lut[i] = 8'hA5;
    s_mem_clr = 1'b1; tick(); s_mem_clr = 1'b0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    check($sformatf("s%0d_flags_cleared_by_start", v), {s_degenerate, s_overflow}, 0);
    for (int i = 0; i < SN; i++) begin
      s_hist_valid = 1'b1;
      s_hist_data  = svecs[v].hist[i];
      tick();
      s_hist_valid = 1'b0;
    end
    t = 0;
    while (s_done_cnt == 0 && t < 200) begin tick(); t++; end
    check($sformatf("s%0d_lut_count", v), s_cnt, SN);
    check($sformatf("s%0d_done_addr", v), s_done_addr, SN - 1);
    for (int i = 0; i < SN; i++) begin
      check($sformatf("s%0d_ram_cdf[%0d]", v, i), s_mem[i], svecs[v].cdf[i]);
      check($sformatf("s%0d_lut[%0d]", v, i), s_lut[i], svecs[v].lut[i]);
    end
    check($sformatf("s%0d_degenerate", v), s_degenerate, svecs[v].deg);
    check($sformatf("s%0d_overflow", v), s_overflow, svecs[v].ovf);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Packed lists run from bin 3 (left) down to bin 0 (right).
    svecs[0] = '{hist: {4'd4, 4'd2, 4'd2, 4'd0}, cdf: {4'd8, 4'd4, 4'd2, 4'd0},
                 lut: {8'd255, 8'd85, 8'd0, 8'd0}, deg: 1'b0, ovf: 1'b0};
    svecs[1] = '{hist: {4'd0, 4'd0, 4'd15, 4'd15}, cdf: {4'd15, 4'd15, 4'd15, 4'd15},
                 lut: {8'd0, 8'd0, 8'd0, 8'd0}, deg: 1'b1, ovf: 1'b1};
    svecs[2] = '{hist: {4'd1, 4'd1, 4'd1, 4'd1}, cdf: {4'd4, 4'd3, 4'd2, 4'd1},
                 lut: {8'd255, 8'd170, 8'd85, 8'd0}, deg: 1'b0, ovf: 1'b0};
    svecs[3] = '{hist: '0, cdf: '0, lut: '0, deg: 1'b1, ovf: 1'b0};
    svecs[4] = '{hist: {4'd1, 4'd4, 4'd3, 4'd2}, cdf: {4'd10, 4'd9, 4'd5, 4'd2},
                 lut: {8'd255, 8'd223, 8'd96, 8'd0}, deg: 1'b0, ovf: 1'b0};

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_big_outputs_zero", b_any_out(), 0);
    check("reset_small_outputs_zero", s_any_out(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) s_run(v);

    for (int i = 0; i < N; i++) b_hist[i] = 1;
    b_frame("ones", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) b_hist[i] = 0;
    b_hist[5] = 1000;
    b_frame("degenerate", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) b_hist[i] = $urandom_range(0, 100);
    b_hist[0] = 32'hFFFF_FFF0;
    b_hist[1] = 32'h0000_0020;
    b_frame("overflow", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) b_hist[i] = $urandom_range(0, 1000);
    b_frame("random_gaps", 1'b1, 1'b1);
    b_frame("random_clean", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) b_hist[i] = 0;
    b_hist[5] = 1000;
    reset_mid_frame();

    for (int i = 0; i < N; i++) b_hist[i] = $urandom_range(0, 5000);
    b_frame("after_reset", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
